dif_bitrev_reorder: RTL and testbench
=====================================

// Module: dif_bitrev_reorder
// PURPOSE
//  Output reorder buffer placed after the last dif_radix2_pe of the DIF SDF pipeline.
//  Accepts one bit-reversed-order frame of N=2^FFT_POINTS_LOG2 complex samples.
//  Emits each frame in natural bin order. Ping-pong: frame k+1 is written while frame k drains.
// PARAMETERS
//  DATA_WIDTH      12  width of each real/imag sample, signed (matches PE DATA_WIDTH_OUT)
//  FFT_POINTS_LOG2 6   log2 of frame length N; legal range 2..12
// PORTS
//  clk         in   1                 clock, rising edge
//  rst_n       in   1                 asynchronous active-low reset
//  halt_ctrl   in   1                 0-halt, 1-run; same global halt the PEs use
//  din_valid   in   1                 din_* carries a sample this cycle
//  din_sof     in   1                 with din_valid: this sample is bin-slot 0 of a new frame
//  din_real    in   DATA_WIDTH        signed
//  din_imag    in   DATA_WIDTH        signed
//  dout_valid  out  1                 dout_* carries an output bin, registered
//  dout_real   out  DATA_WIDTH        signed, registered
//  dout_imag   out  DATA_WIDTH        signed, registered
//  dout_index  out  FFT_POINTS_LOG2   natural bin index j of dout_*
//  dout_eof    out  1                 with dout_valid: last bin (j=N-1)
// BEHAVIOUR
//  Reset: all outputs 0; wr_cnt=0, wr_bank=0, read FSM IDLE, both banks EMPTY. RAM contents are not cleared.
//  halt_ctrl=0: every register, including outputs, holds its value. din is ignored. No RAM write or read is issued.
//  Write side (halt_ctrl=1, din_valid=1):
//    - Write din to RAM[wr_bank][bitrev(wr_cnt)], then wr_cnt++.
//    - When wr_cnt=N-1 is written: mark wr_bank FULL, toggle wr_bank, wr_cnt wraps to 0.
//    - din_sof=1: write forced to slot 0 (wr_cnt treated as 0). Any partial frame in wr_bank is discarded and the bank stays EMPTY.
//    - din_valid=0: no write. wr_cnt holds, so gaps are allowed.
//  Read FSM, states IDLE and DRAIN:
//    - IDLE -> DRAIN on the first run cycle in which the bank at rd_bank is FULL. rd_cnt=0.
//    - DRAIN: issue read RAM[rd_bank][rd_cnt] and increment rd_cnt.
//    - After rd_cnt=N-1: mark rd_bank EMPTY, toggle rd_bank.
//    - Then go to DRAIN if the other bank is FULL (back-to-back, no bubble), otherwise IDLE.
//  Output:
//    - dout_* are registered 1 cycle after the read is issued. dout_index=rd_cnt of that read.
//    - dout_valid=0 whenever no read was issued the previous run cycle. dout_real/imag hold their last value.
//  Latency with continuous input: first sample at cycle 0, dout_valid with j=0 at cycle N+1, j=N-1 at cycle 2N.
//  Overflow cannot occur. Input is at most 1 sample/cycle, drain is exactly 1/cycle, and both sides obey the same halt.
//    - A write that completes a frame into a bank that is not EMPTY is a protocol error.
//    - On that error the frame is dropped and the bank is left untouched.
//  Simultaneous events: same-cycle write-complete and drain-complete on different banks are both applied.
//    - A newly FULL bank is seen by the read FSM the next cycle.
//  Reset mid-frame: partial frames and undrained frames are lost. dout_valid drops to 0 asynchronously.
// CONFIGURATION
//  BITREV_BYPASS_EN defined:
//    - Adds input port bypass_ctrl (1 bit).
//    - Its value is sampled with the first sample written to a bank and stored per bank.
//    - Stored bit 1: that frame is written at address wr_cnt (no reversal). Its output order equals arrival order, with identical latency.
//  BITREV_BYPASS_EN not defined: port absent; always bit-reverse.
// STRUCTURE
//  fft_pkg:
//    - function bitrev(idx, FFT_POINTS_LOG2)
//    - localparam FFT_N = 1<<FFT_POINTS_LOG2
//    - read-FSM state typedef {RD_IDLE, RD_DRAIN}
//    - bank-state typedef {BANK_EMPTY, BANK_FULL}
//  Sub-module bitrev_dpram:
//    - Simple dual-port RAM, 2*FFT_N words x 2*DATA_WIDTH.
//    - 1 write port, 1 registered read port, no reset on the array.
//    - Address is {bank, index}.
//  Top level holds the counters, bank flags, read FSM and output registers.
// TESTING (FFT_POINTS_LOG2=3, N=8, DATA_WIDTH=12)
//  1 Continuous frame:
//    - Stimulus: din_real = 0..7 with sof on the first sample, din_imag = -din_real.
//    - Response: dout_real = 0,4,2,6,1,5,3,7 and dout_index = 0..7.
//    - First dout_valid at cycle 9; dout_eof on index 7.
//  2 Back-to-back frames: 3 frames of 8 samples, no gaps.
//    - Response: 24 contiguous dout_valid cycles, no bubble, frame order preserved.
//  3 Gappy input with halt:
//    - Stimulus: din_valid toggled every other cycle, plus a 5-cycle halt_ctrl=0 pulse during drain.
//    - Response: outputs identical to case 1; all outputs frozen during the halt.
//  4 Resync: 5 samples, then din_sof with a full 8-sample frame.
//    - Response: only the 8-sample frame is output.
//  5 Async reset asserted mid-drain (after index 3):
//    - Response: outputs 0 immediately; the next full frame is output correctly from index 0.
//  6 BITREV_BYPASS_EN build:
//    - Stimulus: frame A with bypass_ctrl=1, then frame B with bypass_ctrl=0.
//    - Response: A is output as 0..7; B is output as 0,4,2,6,1,5,3,7.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared types and helpers for the DIF FFT output reorder slice.
// Holds the bit-reverse helper plus read-FSM and bank-state encodings.
package fft_pkg;

  localparam int FFT_LOG2_DEF = 6;
  localparam int FFT_N        = 1 << FFT_LOG2_DEF;
  localparam int BITREV_MAX   = 12;

  typedef enum logic {
    RD_IDLE,
    RD_DRAIN
  } rd_state_t;

  typedef enum logic {
    BANK_EMPTY,
    BANK_FULL
  } bank_state_t;

  function automatic logic [BITREV_MAX-1:0] bitrev(
    input logic [BITREV_MAX-1:0] idx,
    input int                    bits
  );
    logic [BITREV_MAX-1:0] r;
    r = '0;
    for (int i = 0; i < BITREV_MAX; i++) begin
      if (i < bits) r[i] = idx[4'(bits - 1 - i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/bitrev_dpram.sv
// Simple dual-port RAM: one write port, one registered read port.
// The array itself is never reset; only the read register is.
module bitrev_dpram #(
  parameter int DW = 24,
  parameter int AW = 7
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/dif_bitrev_reorder.sv
// Ping-pong reorder buffer: bit-reversed DIF frames in, natural order out.
// Optional BITREV_BYPASS_EN adds bypass_ctrl for per-frame no-reversal.
module dif_bitrev_reorder
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH      = 12,
  parameter int FFT_POINTS_LOG2 = FFT_LOG2_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
`ifdef BITREV_BYPASS_EN
  input  logic                       bypass_ctrl,
`endif
  input  logic                       halt_ctrl,
  input  logic                       din_valid,
  input  logic                       din_sof,
  input  logic [DATA_WIDTH-1:0]      din_real,
  input  logic [DATA_WIDTH-1:0]      din_imag,
  output logic                       dout_valid,
  output logic [DATA_WIDTH-1:0]      dout_real,
  output logic [DATA_WIDTH-1:0]      dout_imag,
  output logic [FFT_POINTS_LOG2-1:0] dout_index,
  output logic                       dout_eof
);

  localparam int AW = FFT_POINTS_LOG2;
  localparam int N  = 1 << AW;
  localparam logic [AW-1:0] LAST = AW'(N - 1);

  logic              run;
  logic [AW-1:0]     wr_cnt;
  logic [AW-1:0]     wr_idx;
  logic [AW-1:0]     wr_slot;
  logic              wr_bank;
  logic              wr_last;
  logic              wr_ok;
  logic              wr_take;
  logic              ram_we;
  logic              byp_cur;
  bank_state_t       bank_st [2];

  rd_state_t         rd_state;
  rd_state_t         rd_state_nx;
  logic [AW-1:0]     rd_cnt;
  logic [AW-1:0]     rd_cnt_nx;
  logic              rd_bank;
  logic              rd_bank_nx;
  logic              rd_issue;
  logic              rd_done;

  logic [2*DATA_WIDTH-1:0] rd_data;

  assign run     = halt_ctrl;
  assign wr_take = run && din_valid;
  assign wr_idx  = din_sof ? '0 : wr_cnt;
  assign wr_last = (wr_idx == LAST);
  assign wr_ok   = (bank_st[wr_bank] == BANK_EMPTY);
  // A bank still holding a frame must not be overwritten.
  assign ram_we  = wr_take && wr_ok;

`ifdef BITREV_BYPASS_EN
  logic [1:0] byp_q;

  assign byp_cur = (wr_idx == '0) ? bypass_ctrl : byp_q[wr_bank];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byp_q <= '0;
    end else if (ram_we && wr_idx == '0) begin
      byp_q[wr_bank] <= bypass_ctrl;
    end
  end
`else
  assign byp_cur = 1'b0;
`endif

  assign wr_slot = byp_cur ? wr_idx
                 : AW'(bitrev(BITREV_MAX'(wr_idx), AW));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt  <= '0;
      wr_bank <= 1'b0;
    end else if (wr_take) begin
      wr_cnt <= wr_idx + 1'b1;
      if (wr_last && wr_ok) wr_bank <= ~wr_bank;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_st[0] <= BANK_EMPTY;
      bank_st[1] <= BANK_EMPTY;
    end else if (run) begin
      if (rd_done) bank_st[rd_bank] <= BANK_EMPTY;
      if (wr_take && wr_last && wr_ok) bank_st[wr_bank] <= BANK_FULL;
    end
  end

  // IDLE issues slot 0 in the same cycle it sees FULL, saving a bubble.
  always_comb begin
    rd_issue    = 1'b0;
    rd_done     = 1'b0;
    rd_state_nx = rd_state;
    rd_cnt_nx   = rd_cnt;
    rd_bank_nx  = rd_bank;
    if (run) begin
      unique case (rd_state)
        RD_IDLE: begin
          if (bank_st[rd_bank] == BANK_FULL) begin
            rd_issue    = 1'b1;
            rd_cnt_nx   = rd_cnt + 1'b1;
            rd_state_nx = RD_DRAIN;
          end
        end
        RD_DRAIN: begin
          rd_issue  = 1'b1;
          rd_cnt_nx = rd_cnt + 1'b1;
          if (rd_cnt == LAST) begin
            rd_done     = 1'b1;
            rd_bank_nx  = ~rd_bank;
            rd_state_nx = (bank_st[~rd_bank] == BANK_FULL)
                        ? RD_DRAIN : RD_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state <= RD_IDLE;
      rd_cnt   <= '0;
      rd_bank  <= 1'b0;
    end else begin
      rd_state <= rd_state_nx;
      rd_cnt   <= rd_cnt_nx;
      rd_bank  <= rd_bank_nx;
    end
  end

  bitrev_dpram #(
    .DW (2 * DATA_WIDTH),
    .AW (AW + 1)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (ram_we),
    .waddr ({wr_bank, wr_slot}),
    .wdata ({din_real, din_imag}),
    .re    (rd_issue),
    .raddr ({rd_bank, rd_cnt}),
    .rdata (rd_data)
  );

  assign dout_real = rd_data[2*DATA_WIDTH-1:DATA_WIDTH];
  assign dout_imag = rd_data[DATA_WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_valid <= 1'b0;
      dout_index <= '0;
      dout_eof   <= 1'b0;
    end else if (run) begin
      dout_valid <= rd_issue;
      dout_eof   <= rd_issue && (rd_cnt == LAST);
      if (rd_issue) dout_index <= rd_cnt;
    end
  end

endmodule

// File: tb/tb_dif_bitrev_reorder.sv
// Directed bench for dif_bitrev_reorder with N=8, 12-bit samples.
// Covers bypass frames too when BITREV_BYPASS_EN is defined.
module tb_dif_bitrev_reorder;

  localparam int DW = 12;
  localparam int LG = 3;
  localparam int N  = 8;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b0;
  logic          halt_ctrl = 1'b0;
  logic          din_valid = 1'b0;
  logic          din_sof   = 1'b0;
  logic [DW-1:0] din_real  = '0;
  logic [DW-1:0] din_imag  = '0;
  logic          dout_valid;
  logic [DW-1:0] dout_real;
  logic [DW-1:0] dout_imag;
  logic [LG-1:0] dout_index;
  logic          dout_eof;
`ifdef BITREV_BYPASS_EN
  logic          bypass_ctrl = 1'b0;
`endif

  dif_bitrev_reorder #(
    .DATA_WIDTH      (DW),
    .FFT_POINTS_LOG2 (LG)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef BITREV_BYPASS_EN
    .bypass_ctrl(bypass_ctrl),
`endif
    .halt_ctrl  (halt_ctrl),
    .din_valid  (din_valid),
    .din_sof    (din_sof),
    .din_real   (din_real),
    .din_imag   (din_imag),
    .dout_valid (dout_valid),
    .dout_real  (dout_real),
    .dout_imag  (dout_imag),
    .dout_index (dout_index),
    .dout_eof   (dout_eof)
  );

  always #5 clk = ~clk;

  typedef struct {
    int din;
    int re;
    int im;
    int idx;
    int eof;
  } vec_t;

  typedef struct {
    int re;
    int im;
    int idx;
    int eof;
    int cyc;
  } obs_t;

  vec_t tbl [N];
  obs_t q [$];
  int   cyc = 0;
  logic last_run = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always @(posedge clk) begin
    cyc++;
    last_run = halt_ctrl;
  end

  always @(negedge clk) begin
    if (dout_valid && last_run) begin
      q.push_back('{int'($signed(dout_real)), int'($signed(dout_imag)),
                    int'(dout_index), int'(dout_eof), cyc});
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic sof, input int val);
    din_valid = v;
    din_sof   = sof;
    din_real  = DW'(val);
    din_imag  = DW'(-val);
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    din_sof   = 1'b0;
  endtask

  task automatic send_frame(input int base);
    for (int k = 0; k < N; k++) drive(1'b1, k == 0, base + tbl[k].din);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_q(input int n, input int budget);
    int k;
    k = 0;
    while (q.size() < n && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("out_count", q.size(), n);
  endtask

  task automatic chk_frame(input string nm, input int base, input int start);
    for (int j = 0; j < N; j++) begin
      if (start + j < q.size()) begin
        chk($sformatf("%s.re[%0d]", nm, j), q[start+j].re, base + tbl[j].re);
        chk($sformatf("%s.im[%0d]", nm, j), q[start+j].im, -base + tbl[j].im);
        chk($sformatf("%s.idx[%0d]", nm, j), q[start+j].idx, tbl[j].idx);
        chk($sformatf("%s.eof[%0d]", nm, j), q[start+j].eof, tbl[j].eof);
      end
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, ".valid"}, int'(dout_valid), 0);
    chk({nm, ".re"}, int'(dout_real), 0);
    chk({nm, ".im"}, int'(dout_imag), 0);
    chk({nm, ".idx"}, int'(dout_index), 0);
    chk({nm, ".eof"}, int'(dout_eof), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_re [N] = '{0, 4, 2, 6, 1, 5, 3, 7};
    int c0;
    int k;
    int snap [5];

    for (int j = 0; j < N; j++) begin
      tbl[j].din = j;
      tbl[j].re  = exp_re[j];
      tbl[j].im  = -exp_re[j];
      tbl[j].idx = j;
      tbl[j].eof = (j == N - 1) ? 1 : 0;
    end

    // reset state
    #12;
    chk_zero("reset");
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    halt_ctrl = 1'b1;
    idle(2);
    q.delete();

    // 1: single continuous frame
    c0 = cyc;
    send_frame(0);
    wait_q(N, 40);
    chk_frame("f1", 0, 0);
    if (q.size() >= N) begin
      chk("f1.first_cyc", q[0].cyc - c0, N + 1);
      chk("f1.last_cyc", q[N-1].cyc - c0, 2 * N);
    end
    idle(4);
    q.delete();

    // 2: three back-to-back frames
    for (int f = 0; f < 3; f++) send_frame(16 * f);
    wait_q(3 * N, 60);
    for (int f = 0; f < 3; f++) chk_frame($sformatf("f2.%0d", f), 16 * f, N * f);
    if (q.size() >= 3 * N) begin
      for (int i = 1; i < 3 * N; i++)
        chk($sformatf("f2.gap[%0d]", i), q[i].cyc - q[0].cyc, i);
    end
    idle(4);
    q.delete();

    // 3: gappy input plus a halt during drain
    for (int j = 0; j < N; j++) begin
      drive(1'b1, j == 0, j);
      drive(1'b0, 1'b0, 99);
    end
    k = 0;
    while (q.size() < 3 && k < 40) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("f3.pre_halt", int'(q.size() >= 3), 1);
    halt_ctrl = 1'b0;
    snap = '{int'(dout_valid), int'(dout_real), int'(dout_imag),
             int'(dout_index), int'(dout_eof)};
    for (int h = 0; h < 5; h++) begin
      @(negedge clk);
      chk($sformatf("f3.hold_v%0d", h), int'(dout_valid), snap[0]);
      chk($sformatf("f3.hold_re%0d", h), int'(dout_real), snap[1]);
      chk($sformatf("f3.hold_im%0d", h), int'(dout_imag), snap[2]);
      chk($sformatf("f3.hold_ix%0d", h), int'(dout_index), snap[3]);
      chk($sformatf("f3.hold_eof%0d", h), int'(dout_eof), snap[4]);
    end
    @(posedge clk);
    #1;
    halt_ctrl = 1'b1;
    wait_q(N, 40);
    chk_frame("f3", 0, 0);
    idle(4);
    q.delete();

    // 4: partial frame then resync
    for (int j = 0; j < 5; j++) drive(1'b1, j == 0, 100 + j);
    send_frame(0);
    wait_q(N, 40);
    chk_frame("f4", 0, 0);
    idle(20);
    chk("f4.total", q.size(), N);
    q.delete();

    // 5: async reset mid-drain
    send_frame(32);
    k = 0;
    while (q.size() < 4 && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("f5.pre_reset", int'(q.size() >= 4), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("f5.reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);
    q.delete();
    c0 = cyc;
    send_frame(48);
    wait_q(N, 40);
    chk_frame("f5", 48, 0);
    if (q.size() >= 1) chk("f5.first_cyc", q[0].cyc - c0, N + 1);
    idle(4);
    q.delete();

`ifdef BITREV_BYPASS_EN
    // 6: bypass frame A then reversed frame B
    for (int j = 0; j < N; j++) begin
      bypass_ctrl = (j == 0);
      drive(1'b1, j == 0, j);
    end
    bypass_ctrl = 1'b0;
    send_frame(16);
    wait_q(2 * N, 60);
    for (int j = 0; j < N; j++) begin
      if (j < q.size()) begin
        chk($sformatf("f6a.re[%0d]", j), q[j].re, j);
        chk($sformatf("f6a.idx[%0d]", j), q[j].idx, j);
      end
    end
    chk_frame("f6b", 16, N);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
